// File: rtl/multiword_add_sequencer.sv
// Multi-cycle wide adder: streams N-bit chunks, LSW first, through one CarrySelectAdd,
// chaining the registered chunk carry, and returns the W-bit sum over valid/ready.

module CarrySelectAdd #(
  parameter int    N     = 32,
  parameter string MODEL = "Behavioral"
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] c,
  output logic         co
);

  if (MODEL == "DataFlow" && N >= 2) begin : g_dataflow
    localparam int H = N / 2;
    logic [H:0]   lo_s;
    logic [N-H:0] hi0_s;
    logic [N-H:0] hi1_s;

    // Upper half is precomputed for both possible carries; the low half's carry picks one.
    assign lo_s  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, ci};
    assign hi0_s = {1'b0, a[N-1:H]} + {1'b0, b[N-1:H]};
    assign hi1_s = hi0_s + {{(N-H){1'b0}}, 1'b1};
    assign c     = {(lo_s[H] ? hi1_s[N-H-1:0] : hi0_s[N-H-1:0]), lo_s[H-1:0]};
    assign co    = lo_s[H] ? hi1_s[N-H] : hi0_s[N-H];
  end else if (MODEL == "Structural") begin : g_structural
    logic [N:0] cy_s;

    assign cy_s[0] = ci;
    for (genvar i = 0; i < N; i++) begin : g_fa
      assign c[i]      = a[i] ^ b[i] ^ cy_s[i];
      assign cy_s[i+1] = (a[i] & b[i]) | (cy_s[i] & (a[i] ^ b[i]));
    end
    assign co = cy_s[N];
  end else begin : g_behavioral
    assign {co, c} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
  end

endmodule

module multiword_add_sequencer #(
  parameter int    N     = 32,
  parameter int    WORDS = 4,
  parameter string MODEL = "Behavioral"
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] in_a,
  input  logic [N*WORDS-1:0] in_b,
  input  logic               in_ci,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] out_c,
  output logic               out_co
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] idx_r, idx_s;
  logic [W-1:0]  a_r, a_s;
  logic [W-1:0]  b_r, b_s;
  logic [W-1:0]  res_r, res_s;
  logic          carry_r, carry_s;
  logic          co_r, co_s;
  logic          in_ready_r, in_ready_s;
  logic          out_valid_r, out_valid_s;

  logic [31:0]   base_s;
  logic [N-1:0]  add_a_s;
  logic [N-1:0]  add_b_s;
  logic [N-1:0]  add_c_s;
  logic          add_co_s;

  assign base_s  = 32'(idx_r) * 32'(N);
  assign add_a_s = a_r[base_s +: N];
  assign add_b_s = b_r[base_s +: N];

  CarrySelectAdd #(
    .N     (N),
    .MODEL (MODEL)
  ) u_add (
    .a  (add_a_s),
    .b  (add_b_s),
    .ci (carry_r),
    .c  (add_c_s),
    .co (add_co_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    a_s         = a_r;
    b_s         = b_r;
    res_s       = res_r;
    carry_s     = carry_r;
    co_s        = co_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid && in_ready_r) begin
          a_s        = in_a;
          b_s        = in_b;
          carry_s    = in_ci;
          idx_s      = {IW{1'b0}};
          in_ready_s = 1'b0;
          state_s    = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        res_s[base_s +: N] = add_c_s;
        carry_s            = add_co_s;
        if (idx_r == IW'(WORDS - 1)) begin
          idx_s       = {IW{1'b0}};
          co_s        = add_co_s;
          out_valid_s = 1'b1;
          state_s     = DONE;
        end else begin
          idx_s = idx_r + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          in_ready_s  = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s     = IDLE;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= {IW{1'b0}};
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      res_r       <= {W{1'b0}};
      carry_r     <= 1'b0;
      co_r        <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      a_r         <= a_s;
      b_r         <= b_s;
      res_r       <= res_s;
      carry_r     <= carry_s;
      co_r        <= co_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_c     = res_r;
  assign out_co    = co_r;

endmodule
